serdes_tx_fifo: RTL and testbench
=================================

SERDES_TX_FIFO -- requirements
Module: serdes_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (legal range 5..16).
REQ-002 Parameter DEPTH, default 4, FIFO word capacity (power of 2, at least 2).
REQ-003 Parameter PARITY_EN, default 1: 1 = insert even-parity bit, 0 = no parity bit.
REQ-004 Port CLOCK_50  input  1  sole clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port Pin  input  DATA_W  parallel word to transmit.
REQ-007 Port send  input  1  write strobe; a word is pushed on each rising edge where send=1, one word per cycle, no edge detection.
REQ-008 Port Sout  output  1  registered serial line, idle level 1.
REQ-009 Port busy  output  1  high while a frame is on the line (any state other than IDLE).
REQ-010 Port full  output  1  high when the FIFO holds DEPTH words.
REQ-011 Port fifoCount  output  clog2(DEPTH)+1  number of words currently queued.
REQ-012 Port errTX  output  1  sticky overflow flag.

Function
REQ-013 Frame format, one bit per clock:
 - start bit 0
 - DATA_W data bits, LSB first
 - parity bit (XOR of data bits) when PARITY_EN=1
 - stop bit 1
REQ-014 Frame length is DATA_W+2+PARITY_EN cycles.
REQ-015 FSM states and transitions:
 - IDLE: leave to START when the FIFO is non-empty.
 - START: go to DATA.
 - DATA: go to PARITY (or STOP if PARITY_EN=0) after DATA_W bits.
 - PARITY: go to STOP.
 - STOP: go to START if the FIFO is non-empty, else IDLE.
REQ-016 Pop occurs on the edge that enters START; the popped word loads the shift register and the parity register.
REQ-017 Latency: a word pushed at edge k into an empty FIFO while in IDLE gives start bit on Sout from edge k+1, data bit i from edge k+2+i.
REQ-018 Back-to-back frames: stop bit is followed directly by the next start bit, with no idle cycle.
REQ-019 Sout=1 in IDLE and STOP.
REQ-020 Push when not full: the word is written and fifoCount increments, unless a pop happens on the same edge, in which case the count is unchanged.
REQ-021 Push when full with no same-edge pop: the word is dropped, the FIFO is unchanged and errTX is set.
REQ-022 Push when full with a same-edge pop: the word is accepted and errTX is unchanged.
REQ-023 Push into an empty FIFO in IDLE: the word is written at edge k and popped at edge k+1; fifoCount reads 1 for one cycle.
REQ-024 FIFO pointers wrap modulo DEPTH; order is strictly first-in first-out.
REQ-025 errTX stays at 1 until reset.
REQ-026 Pin is sampled only on push edges; Pin changes mid-frame do not affect the frame on the line.

Reset
REQ-027 While reset=1, asynchronously:
 - Sout=1, busy=0, full=0, fifoCount=0, errTX=0
 - FSM forced to IDLE
 - FIFO pointers cleared
REQ-028 Reset mid-frame aborts the frame immediately (line returns to 1) and discards all queued words.
REQ-029 After reset deasserts, no frame starts until a new push occurs.

Verification
REQ-030 DATA_W=8, PARITY_EN=1; push 8'h0F once -> Sout from edge k+1: 0,1,1,1,1,0,0,0,0,0,1, then 1 idle; busy high for 11 cycles.
REQ-031 Push 8'h07 then 8'hF0 on consecutive cycles -> two contiguous frames: 0,1,1,1,0,0,0,0,0,1,1 then 0,0,0,0,0,1,1,1,1,0,1, no gap between them; fifoCount peaks at 1.
REQ-032 DEPTH=4; push 6 words on consecutive cycles starting in IDLE -> first word popped, 4 queued, full=1, 6th word dropped, errTX=1; exactly 5 frames transmitted.
REQ-033 With FIFO full, push on the same edge as a STOP-to-START pop -> word accepted, fifoCount stays 4, errTX stays 0.
REQ-034 Assert reset during data bit 3 of a frame with 2 words queued -> Sout=1 in the same cycle; fifoCount=0, busy=0, errTX=0; no further frames after release.
REQ-035 PARITY_EN=0, DATA_W=5; push 5'h15 -> frame 0,1,0,1,0,1,1 (7 cycles).

Source files
------------

// File: rtl/serdes_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : serdes_tx_fifo
// Purpose  : Parallel-to-serial transmitter fed by a small synchronous FIFO.
//            Each queued word goes out as one frame: start bit (0), DATA_W
//            data bits LSB first, an optional even-parity bit, and a stop
//            bit (1). Consecutive frames are sent back-to-back with no gap.
// Revision : 1.0  initial release
// ============================================================================
module serdes_tx_fifo #(
  parameter int DATA_W    = 8,  // payload bits per frame (5..16)
  parameter int DEPTH     = 4,  // FIFO capacity in words (power of 2, >= 2)
  parameter int PARITY_EN = 1   // 1: append even-parity bit, 0: no parity
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        Pin,
  input  logic                     send,
  output logic                     Sout,
  output logic                     busy,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     errTX
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam int c_BIT_W  = 5;  // wide enough to count up to 16 data bits

  localparam logic [c_CNT_W-1:0]  c_FULL_CNT = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
  localparam logic [c_BIT_W-1:0]  c_LAST_BIT = c_BIT_W'(DATA_W);
  localparam logic [c_BIT_W-1:0]  c_BIT_ONE  = c_BIT_W'(1);

  // Line FSM encoding
  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_START  = 3'd1;
  localparam logic [2:0] c_DATA   = 3'd2;
  localparam logic [2:0] c_PARITY = 3'd3;
  localparam logic [2:0] c_STOP   = 3'd4;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_err;

  logic [2:0]          r_state;
  logic [DATA_W-1:0]   r_shreg;
  logic                r_par;
  logic [c_BIT_W-1:0]  r_bitcnt;
  logic                r_sout;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_head;
  logic              w_head_par;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_FULL_CNT);

  // A pop happens only on the edge that enters START, i.e. from IDLE or STOP
  // when something is queued. It looks at the registered count, so a word
  // written on this same edge is not yet visible to it.
  assign w_pop  = ((r_state == c_IDLE) || (r_state == c_STOP)) && !w_empty;

  // A full FIFO can still take a word if a slot frees up on the same edge;
  // in that case the write slot equals the read slot, and the read sees the
  // old contents because the write is non-blocking.
  assign w_push = send && (!w_full || w_pop);
  assign w_drop = send && w_full && !w_pop;

  assign w_head = r_mem[r_rd_ptr];

  generate
    if (PARITY_EN != 0) begin : g_parity
      assign w_head_par = ^w_head;
    end else begin : g_no_parity
      assign w_head_par = 1'b0;
    end
  endgenerate

  // Word storage; contents need no reset because the pointers define validity
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= Pin;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH (power of 2)
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - c_CNT_ONE;
      end
    end
  end

  // Sticky overflow flag: set when a word is dropped, cleared only by reset
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_drop) begin
      r_err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Line FSM. Sout is registered and is loaded with the bit belonging to the
  // state being entered, so the line value always matches the current state.
  // --------------------------------------------------------------------------
  // Frame sequencing, shift register and registered serial output
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state  <= c_IDLE;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_bitcnt <= '0;
      r_sout   <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pop) begin
            r_state <= c_START;
            r_shreg <= w_head;
            r_par   <= w_head_par;
            r_sout  <= 1'b0;
          end else begin
            r_sout  <= 1'b1;
          end
        end

        c_START: begin
          // First data bit goes out as DATA is entered
          r_state  <= c_DATA;
          r_sout   <= r_shreg[0];
          r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
          r_bitcnt <= c_BIT_ONE;
        end

        c_DATA: begin
          if (r_bitcnt == c_LAST_BIT) begin
            if (PARITY_EN != 0) begin
              r_state <= c_PARITY;
              r_sout  <= r_par;
            end else begin
              r_state <= c_STOP;
              r_sout  <= 1'b1;
            end
          end else begin
            r_sout   <= r_shreg[0];
            r_shreg  <= {1'b0, r_shreg[DATA_W-1:1]};
            r_bitcnt <= r_bitcnt + c_BIT_ONE;
          end
        end

        c_PARITY: begin
          r_state <= c_STOP;
          r_sout  <= 1'b1;
        end

        c_STOP: begin
          // Next queued word starts immediately, no idle bit in between
          if (w_pop) begin
            r_state <= c_START;
            r_shreg <= w_head;
            r_par   <= w_head_par;
            r_sout  <= 1'b0;
          end else begin
            r_state <= c_IDLE;
            r_sout  <= 1'b1;
          end
        end

        default: begin
          r_state <= c_IDLE;
          r_sout  <= 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Sout      = r_sout;
  assign busy      = (r_state != c_IDLE);
  assign full      = w_full;
  assign fifoCount = r_count;
  assign errTX     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serdes_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_serdes_tx_fifo
// Purpose  : Directed self-checking bench for serdes_tx_fifo. One instance
//            with 8-bit data and parity, one with 5-bit data and no parity.
// Revision : 1.0  initial release
// ============================================================================
module tb_serdes_tx_fifo;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;

  logic [7:0] pin8  = '0;
  logic       send8 = 1'b0;
  logic       sout8, busy8, full8, err8;
  logic [2:0] cnt8;

  logic [4:0] pin5  = '0;
  logic       send5 = 1'b0;
  logic       sout5, busy5, full5, err5;
  logic [2:0] cnt5;

  int total = 0;
  int bad   = 0;

  // Expected serial stream of the 8-bit instance, one entry per clock
  logic exp_q [$];

  serdes_tx_fifo #(.DATA_W(8), .DEPTH(4), .PARITY_EN(1)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .Pin      (pin8),
    .send     (send8),
    .Sout     (sout8),
    .busy     (busy8),
    .full     (full8),
    .fifoCount(cnt8),
    .errTX    (err8)
  );

  serdes_tx_fifo #(.DATA_W(5), .DEPTH(4), .PARITY_EN(0)) dut5 (
    .CLOCK_50 (clk),
    .reset    (reset),
    .Pin      (pin5),
    .send     (send5),
    .Sout     (sout5),
    .busy     (busy5),
    .full     (full5),
    .fifoCount(cnt5),
    .errTX    (err5)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, compare against the expected stream
  task automatic tick();
    logic b;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      b = exp_q.pop_front();
      check("sout_stream", {31'd0, sout8}, {31'd0, b});
      check("busy_stream", {31'd0, busy8}, 32'd1);
    end
  endtask

  // Hand-written 11-bit frame, first transmitted bit in the MSB
  task automatic append_bits(input logic [10:0] v);
    for (int i = 10; i >= 0; i--) exp_q.push_back(v[i]);
  endtask

  // Reference frame: start, data LSB first, even parity, stop
  task automatic append_frame8(input logic [7:0] w);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(w[i]);
    exp_q.push_back(^w);
    exp_q.push_back(1'b1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_done", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] w4 [6];
    logic [7:0] b5 [6];
    logic [6:0] v5;
    int         maxc;
    int         guard;

    w4 = '{8'h3C, 8'hA5, 8'h81, 8'h5A, 8'hFF, 8'h00};
    b5 = '{8'h12, 8'h34, 8'hC3, 8'h7E, 8'h01, 8'h96};

    // ---- Reset values while reset is held --------------------------------
    #1 reset = 1'b1;
    #2;
    check("rst_sout",  {31'd0, sout8}, 32'd1);
    check("rst_busy",  {31'd0, busy8}, 32'd0);
    check("rst_full",  {31'd0, full8}, 32'd0);
    check("rst_count", {29'd0, cnt8},  32'd0);
    check("rst_err",   {31'd0, err8},  32'd0);
    check("rst_sout5", {31'd0, sout5}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    tick();
    check("idle_no_frame", {30'd0, sout8, busy8}, 32'h2);

    // ---- Single word 0x0F ------------------------------------------------
    pin8 = 8'h0F; send8 = 1'b1;
    tick();
    send8 = 1'b0; pin8 = 8'hA5;
    check("0f_count_k",  {29'd0, cnt8},  32'd1);
    check("0f_sout_k",   {31'd0, sout8}, 32'd1);
    check("0f_busy_k",   {31'd0, busy8}, 32'd0);
    append_bits(11'b01111000001);
    tick();
    check("0f_count_k1", {29'd0, cnt8},  32'd0);
    for (int i = 0; i < 10; i++) tick();
    tick();
    check("0f_idle_after", {30'd0, sout8, busy8}, 32'h2);

    // ---- Two back-to-back words 0x07, 0xF0 -------------------------------
    pin8 = 8'h07; send8 = 1'b1;
    tick();
    check("b2b_count_k", {29'd0, cnt8}, 32'd1);
    append_bits(11'b01110000011);
    pin8 = 8'hF0;
    tick();
    send8 = 1'b0; pin8 = 8'h3C;
    append_bits(11'b00000111101);
    maxc  = int'(cnt8);
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      if (int'(cnt8) > maxc) maxc = int'(cnt8);
      guard++;
    end
    check("b2b_count_peak", maxc, 32'd1);
    tick();
    check("b2b_idle_after", {30'd0, sout8, busy8}, 32'h2);

    // ---- Six words into a depth-4 FIFO: last one dropped -----------------
    for (int i = 0; i < 6; i++) begin
      pin8 = w4[i]; send8 = 1'b1;
      tick();
      if (i == 0) begin
        for (int j = 0; j < 5; j++) append_frame8(w4[j]);
      end
    end
    send8 = 1'b0; pin8 = 8'h55;
    check("ovf_count", {29'd0, cnt8},  32'd4);
    check("ovf_full",  {31'd0, full8}, 32'd1);
    check("ovf_err",   {31'd0, err8},  32'd1);
    drain();
    tick();
    check("ovf_idle_after", {30'd0, sout8, busy8}, 32'h2);
    check("ovf_count_end",  {29'd0, cnt8},  32'd0);
    check("ovf_err_sticky", {31'd0, err8},  32'd1);

    // ---- Push into full FIFO on the STOP-to-START pop edge ---------------
    do_reset();
    check("post_rst_err", {31'd0, err8}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      pin8 = b5[i]; send8 = 1'b1;
      tick();
      if (i == 0) begin
        for (int j = 0; j < 5; j++) append_frame8(b5[j]);
      end
    end
    send8 = 1'b0; pin8 = 8'hEE;
    repeat (7) tick();
    check("pre_pop_full",  {31'd0, full8}, 32'd1);
    check("pre_pop_count", {29'd0, cnt8},  32'd4);
    pin8 = b5[5]; send8 = 1'b1;
    tick();
    send8 = 1'b0; pin8 = 8'h11;
    check("popedge_count", {29'd0, cnt8},  32'd4);
    check("popedge_full",  {31'd0, full8}, 32'd1);
    check("popedge_err",   {31'd0, err8},  32'd0);
    append_frame8(b5[5]);
    drain();
    tick();
    check("popedge_idle_after", {30'd0, sout8, busy8}, 32'h2);
    check("popedge_err_end",    {31'd0, err8},  32'd0);

    // ---- Reset mid-frame during data bit 3 with two words queued ---------
    do_reset();
    pin8 = 8'h05; send8 = 1'b1;
    tick();
    append_frame8(8'h05);
    pin8 = 8'h66;
    tick();
    pin8 = 8'h99;
    tick();
    send8 = 1'b0;
    check("midrst_queued", {29'd0, cnt8}, 32'd2);
    tick();
    tick();
    tick();
    check("midrst_bit3_low", {31'd0, sout8}, 32'd0);
    reset = 1'b1;
    #2;
    check("midrst_sout",  {31'd0, sout8}, 32'd1);
    check("midrst_count", {29'd0, cnt8},  32'd0);
    check("midrst_busy",  {31'd0, busy8}, 32'd0);
    check("midrst_err",   {31'd0, err8},  32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check("midrst_quiet", {30'd0, sout8, busy8}, 32'h2);
    end

    // ---- 5-bit, no parity: 5'h15 ----------------------------------------
    pin5 = 5'h15; send5 = 1'b1;
    tick();
    send5 = 1'b0; pin5 = 5'h0A;
    check("w5_count_k", {29'd0, cnt5},  32'd1);
    check("w5_sout_k",  {31'd0, sout5}, 32'd1);
    v5 = 7'b0101011;
    for (int i = 6; i >= 0; i--) begin
      tick();
      check("w5_sout", {31'd0, sout5}, {31'd0, v5[i]});
      check("w5_busy", {31'd0, busy5}, 32'd1);
    end
    tick();
    check("w5_idle_after", {30'd0, sout5, busy5}, 32'h2);
    check("w5_flags", {30'd0, full5, err5}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
